// File: rtl/vdp_mux_pkg.sv
// Shared definitions for the 4:1 mux round-robin sequencer.
// Holds the FSM state encoding, the channel count and the round-robin pick helper.
// Pure definitions: no logic, so no latency or backpressure of its own.
package vdp_mux_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam int         NUM_CH  = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SEL  = ST_SEL,
    S_HOLD = ST_HOLD
  } state_t;

  // Search last+1, last+2, last+3, last (mod 4); the first set bit wins.
  // Iterating from the farthest offset down lets the nearest hit overwrite.
  function automatic logic [1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                         input logic [1:0]        last);
    logic [1:0] c;
    rr_pick = last;
    for (int i = NUM_CH; i >= 1; i--) begin
      c = last + i[1:0];
      if (req[c]) rr_pick = c;
    end
  endfunction

endpackage

// File: rtl/mux4_rr_sequencer_if.sv
// Bundle of the source-side and downstream-side signals of the sequencer.
// master = sequencer side, slave = environment (sources, mux, downstream).
// No logic inside; timing is owned by the modules on either side.
interface mux4_rr_sequencer_if #(
  parameter int BITS = 16
);
  logic [3:0]      req;
  logic [BITS-1:0] mux_out;
  logic            s0;
  logic            s1;
  logic [3:0]      gnt;
  logic [BITS-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;

  modport master (
    input  req, mux_out, dout_ready,
    output s0, s1, gnt, dout, dout_valid
  );

  modport slave (
    output req, mux_out, dout_ready,
    input  s0, s1, gnt, dout, dout_valid
  );
endinterface

// File: rtl/rr_arb4.sv
// Combinational round-robin pick over four requests, optionally masking 'last'.
// Zero latency: pure combinational function of req/last/mask_last.
// No backpressure; vld=0 simply means nothing eligible this cycle.
module rr_arb4
  import vdp_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last,
  input  logic              mask_last,
  output logic              vld,
  output logic [1:0]        ch
);

  logic [NUM_CH-1:0] masked;

  // Drop the just-served channel when asked, then rotate from last+1.
  always_comb begin
    masked = req;
    if (mask_last) masked[last] = 1'b0;
    vld = |masked;
    ch  = rr_pick(masked, last);
  end

endmodule

// File: rtl/mux4_rr_sequencer.sv
// Round-robin sequencer: drives 4:1 mux selects, pops the served source, registers the word.
// Latency: req in IDLE -> dout_valid two edges later; at most one word every two cycles.
// Backpressure: dout/dout_valid held in HOLD until dout_ready; no new grant meanwhile.
module mux4_rr_sequencer
  import vdp_mux_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux4_rr_sequencer_if.master  bus
);

  state_t          state, state_nxt;
  logic [1:0]      sel, sel_nxt;
  logic [1:0]      last, last_nxt;
  logic [BITS-1:0] dout_q, dout_nxt;
  logic            valid_q, valid_nxt;
  logic [3:0]      gnt_q, gnt_nxt;

  logic            pick_vld;
  logic [1:0]      pick_ch;
  logic            mask_last;

  // In HOLD the served source may still show a stale req, so hide it.
  assign mask_last = (state == S_HOLD);

  rr_arb4 u_arb (
    .req       (bus.req),
    .last      (last),
    .mask_last (mask_last),
    .vld       (pick_vld),
    .ch        (pick_ch)
  );

  // Next-state and next-register values; gnt is prepared one cycle ahead so it is high exactly in SEL.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    dout_nxt  = dout_q;
    valid_nxt = valid_q;
    gnt_nxt   = 4'b0000;
    case (state)
      S_IDLE: begin
        valid_nxt = 1'b0;
        if (pick_vld) begin
          sel_nxt   = pick_ch;
          gnt_nxt   = 4'b0001 << pick_ch;
          state_nxt = S_SEL;
        end
      end
      S_SEL: begin
        dout_nxt  = bus.mux_out;
        valid_nxt = 1'b1;
        last_nxt  = sel;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.dout_ready) begin
          valid_nxt = 1'b0;
          if (pick_vld) begin
            sel_nxt   = pick_ch;
            gnt_nxt   = 4'b0001 << pick_ch;
            state_nxt = S_SEL;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, select, data and grant registers; last=3 so channel 0 is first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sel     <= 2'd0;
      last    <= 2'd3;
      dout_q  <= '0;
      valid_q <= 1'b0;
      gnt_q   <= 4'b0000;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      last    <= last_nxt;
      dout_q  <= dout_nxt;
      valid_q <= valid_nxt;
      gnt_q   <= gnt_nxt;
    end
  end

  assign bus.s0         = sel[0];
  assign bus.s1         = sel[1];
  assign bus.gnt        = gnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// Self-checking bench for mux4_rr_sequencer: queue-based sources, behavioural mux, RR model.
// Directed cases for reset, latency, rotation, backpressure, mid-run reset and req drop.
// Randomized phase drains random queue loads under random dout_ready.
module tb_mux4_rr_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  mux4_rr_sequencer_if #(.BITS(16)) bus ();

  mux4_rr_sequencer #(.BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Source words waiting per channel; head is what the source shows on xc.
  logic [15:0] q [4][$];
  logic [15:0] x [4];
  logic [3:0]  req_kill;
  assign bus.mux_out = x[{bus.s1, bus.s0}];

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          last_m = 3;
  int          gnt_ch[$];
  int          gnt_cyc[$];
  logic [15:0] acc_w[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference choice: nearest non-empty source after the last served one, wrapping to it.
  function automatic int model_pick();
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last_m + k) % 4;
      if (q[c].size() != 0) return c;
    end
    return last_m;
  endfunction

  function automatic bit pending();
    bit p;
    p = bus.dout_valid || (bus.gnt != 4'b0000);
    for (int c = 0; c < 4; c++) if (q[c].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drive_src();
    for (int c = 0; c < 4; c++) begin
      bus.req[c] = (q[c].size() != 0) && !req_kill[c];
      x[c]       = (q[c].size() != 0) ? q[c][0] : 16'h0000;
    end
  endtask

  // One clock: observe this cycle, advance, check the result, update sources.
  task automatic tick();
    logic [3:0]  g;
    logic        hold_v;
    logic [15:0] hold_d;
    logic [1:0]  sel_b;
    logic [15:0] w;
    int          ch;
    g      = bus.gnt;
    hold_v = bus.dout_valid && !bus.dout_ready;
    hold_d = bus.dout;
    sel_b  = {bus.s1, bus.s0};
    w      = 16'h0000;
    ch     = 0;
    if (bus.dout_valid && bus.dout_ready) acc_w.push_back(bus.dout);
    if (g != 4'b0000) begin
      chk("gnt_onehot", {31'd0, $onehot(g)}, 32'd1);
      chk("gnt_matches_sel", {28'd0, g}, 32'd1 << sel_b);
      chk("gnt_without_valid", {31'd0, bus.dout_valid}, 32'd0);
      for (int c = 0; c < 4; c++) if (g[c]) ch = c;
      chk("rr_order", ch, model_pick());
      last_m = ch;
      if (q[ch].size() != 0) w = q[ch][0];
      gnt_ch.push_back(ch);
      gnt_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g != 4'b0000) begin
      chk("cap_valid", {31'd0, bus.dout_valid}, 32'd1);
      chk("cap_data", {16'd0, bus.dout}, {16'd0, w});
      if (q[ch].size() != 0) void'(q[ch].pop_front());
    end
    if (hold_v) begin
      chk("hold_valid", {31'd0, bus.dout_valid}, 32'd1);
      chk("hold_data", {16'd0, bus.dout}, {16'd0, hold_d});
      chk("hold_no_gnt", {28'd0, bus.gnt}, 32'd0);
      chk("hold_sel", {30'd0, bus.s1, bus.s0}, {30'd0, sel_b});
    end
    drive_src();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) q[c].delete();
    req_kill       = 4'b0000;
    bus.dout_ready = 1'b0;
    drive_src();
    last_m = 3;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int max, input bit rnd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!pending()) begin
        done = 1'b1;
        break;
      end
      bus.dout_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
    end
    chk("drain_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    req_kill       = 4'b0000;
    bus.dout_ready = 1'b0;
    drive_src();
    #1;
    chk("rst_s0", {31'd0, bus.s0}, 32'd0);
    chk("rst_s1", {31'd0, bus.s1}, 32'd0);
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_dout", {16'd0, bus.dout}, 32'd0);
    chk("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    do_reset();

    // Single request: SEL after one edge, word valid after two, then held under backpressure.
    q[0].push_back(16'hA5A5);
    drive_src();
    tick();
    chk("t1_gnt", {28'd0, bus.gnt}, 32'h1);
    chk("t1_sel", {30'd0, bus.s1, bus.s0}, 32'd0);
    chk("t1_valid_sel", {31'd0, bus.dout_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, bus.dout_valid}, 32'd1);
    chk("t1_dout", {16'd0, bus.dout}, 32'hA5A5);
    chk("t1_gnt_off", {28'd0, bus.gnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_valid", {31'd0, bus.dout_valid}, 32'd1);
      chk("t4_dout", {16'd0, bus.dout}, 32'hA5A5);
      chk("t4_gnt", {28'd0, bus.gnt}, 32'd0);
      chk("t4_sel", {30'd0, bus.s1, bus.s0}, 32'd0);
    end
    bus.dout_ready = 1'b1;
    tick();
    chk("t4_release", {31'd0, bus.dout_valid}, 32'd0);

    // All four requesting with ready high: strict rotation, one word per two cycles.
    do_reset();
    gnt_ch.delete();
    gnt_cyc.delete();
    for (int c = 0; c < 4; c++) begin
      q[c].push_back(16'(16'h0100 * c + 1));
      q[c].push_back(16'(16'h0100 * c + 2));
    end
    drive_src();
    drain(100, 1'b0);
    chk("t2_count", gnt_ch.size(), 8);
    if (gnt_ch.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("t2_rotation", gnt_ch[i], i % 4);
      for (int i = 0; i < 4; i++) chk("t2_gap", gnt_cyc[i+1] - gnt_cyc[i], 2);
    end

    // Sparse requests 1010 from reset: ch1 then ch3.
    do_reset();
    acc_w.delete();
    q[1].push_back(16'h1111);
    q[3].push_back(16'h3333);
    drive_src();
    drain(50, 1'b0);
    chk("t3_count", acc_w.size(), 2);
    if (acc_w.size() == 2) begin
      chk("t3_first", {16'd0, acc_w[0]}, 32'h1111);
      chk("t3_second", {16'd0, acc_w[1]}, 32'h3333);
    end

    // Reset while a word sits in HOLD clears everything at once.
    do_reset();
    q[1].push_back(16'h1234);
    drive_src();
    tick();
    tick();
    chk("t5_in_hold", {31'd0, bus.dout_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("t5_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("t5_dout", {16'd0, bus.dout}, 32'd0);
    chk("t5_s0", {31'd0, bus.s0}, 32'd0);
    chk("t5_s1", {31'd0, bus.s1}, 32'd0);
    do_reset();
    q[2].push_back(16'h2468);
    drive_src();
    bus.dout_ready = 1'b1;
    tick();
    chk("t5_first_gnt", {28'd0, bus.gnt}, 32'h4);
    chk("t5_first_sel", {30'd0, bus.s1, bus.s0}, 32'd2);
    drain(50, 1'b0);

    // req[2] dropped during SEL: still captured, next pick moves on to ch3.
    do_reset();
    q[2].push_back(16'h2222);
    q[2].push_back(16'h2223);
    q[3].push_back(16'h3333);
    bus.dout_ready = 1'b1;
    drive_src();
    tick();
    chk("t6_gnt2", {28'd0, bus.gnt}, 32'h4);
    req_kill = 4'b0100;
    drive_src();
    tick();
    chk("t6_dout", {16'd0, bus.dout}, 32'h2222);
    req_kill = 4'b0000;
    drive_src();
    tick();
    chk("t6_next_gnt", {28'd0, bus.gnt}, 32'h8);
    drain(50, 1'b0);

    // Random loads drained under random backpressure, checked by the RR model.
    begin
      int loaded;
      loaded = 0;
      do_reset();
      acc_w.delete();
      for (int r = 0; r < 20; r++) begin
        for (int c = 0; c < 4; c++) begin
          int n;
          n = $urandom_range(0, 4);
          for (int k = 0; k < n; k++) q[c].push_back(16'($urandom));
          loaded += n;
        end
        drive_src();
        drain(200, 1'b1);
      end
      chk("rand_delivered", acc_w.size(), loaded);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
